multicycle_main_control: RTL and testbench



---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/func_encoder.sv | 32 +++
 rtl/multicycle_main_control.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multi-cycle main control FSM and its Func encoder.
//   - state_t     : FSM states (S_TRAP exists only when OVERFLOW_TRAP_EN is defined)
//   - OP_*        : RISC-V major opcodes the controller recognises
//   - ALUOP_*     : ALUOp codes sent to the ALU control decoder
//   - FUNC_*      : 6-bit Func codes consumed by the ALU control decoder
//   - SRCB_*      : ALUSrcB mux select codes
//   - F7_*        : funct7 patterns for the supported R-type operations
// Optional feature macro: OVERFLOW_TRAP_EN
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEMADDR    = 4'd2,
    S_MEM_ACCESS = 4'd3,
    S_WB_MEM     = 4'd4,
    S_EXEC_R     = 4'd5,
    S_WB_ALU     = 4'd6,
    S_BRANCH     = 4'd7,
    S_ILLEGAL    = 4'd8
`ifdef OVERFLOW_TRAP_EN
    ,
    S_TRAP       = 4'd9
`endif
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [5:0] FUNC_NONE = 6'b000000;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/func_encoder.sv
// func_encoder
// Purely combinational map from an R-type (funct7, funct3) pair to the 6-bit
// Func code of the ALU control decoder, plus a legality flag. The same
// instance drives both the DECODE legality check and the EXEC_R/WB_ALU Func.
// Ports:
//   funct7 in  7  instruction bits [31:25]
//   funct3 in  3  instruction bits [14:12]
//   func   out 6  Func code (FUNC_NONE when not legal)
//   legal  out 1  pair is one of add/sub/and/or/slt
module func_encoder
  import ctrl_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [5:0] func,
  output logic       legal
);

  always_comb begin
    func  = FUNC_NONE;
    legal = 1'b0;
    case ({funct7, funct3})
      {F7_BASE, 3'b000}: begin func = FUNC_ADD; legal = 1'b1; end
      {F7_ALT,  3'b000}: begin func = FUNC_SUB; legal = 1'b1; end
      {F7_BASE, 3'b111}: begin func = FUNC_AND; legal = 1'b1; end
      {F7_BASE, 3'b110}: begin func = FUNC_OR;  legal = 1'b1; end
      {F7_BASE, 3'b010}: begin func = FUNC_SLT; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Main control FSM of the multi-cycle RISC-V datapath. Sequences
// FETCH -> DECODE -> {MEMADDR -> MEM_ACCESS [-> WB_MEM] | EXEC_R -> WB_ALU |
// BRANCH | ILLEGAL}, drives ALUOp/Func into the ALU control decoder and
// handshakes with instruction memory (InstrReq/InstrValid) and data memory
// (MemRead/MemWrite/MemAck).
// Parameters:
//   MEM_TIMEOUT  cycles allowed in MEM_ACCESS without MemAck (0 = wait forever)
//   CNT_W        width of the retired-instruction counter
// Ports:
//   clk, rst_n (synchronous, active-low)
//   Instr/InstrValid         fetch response
//   Zero/Overflow            ALU status
//   MemAck                   data memory completion
//   InstrReq, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp, Func,
//   MemRead, MemWrite, RegWrite, MemtoReg  datapath controls
//   Illegal                  sticky unsupported-instruction flag
//   MemErr                   one-cycle pulse on memory timeout
//   Retired                  retired-instruction count (wraps)
// Optional feature macro: OVERFLOW_TRAP_EN adds Trap (out) / TrapAck (in) and
// the TRAP state entered when add/sub overflows in EXEC_R.
// Outputs are combinational from the registered state and latched IR fields.
module multicycle_main_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr,
  input  logic             InstrValid,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             MemAck,
  output logic             InstrReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [5:0]       Func,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Illegal,
  output logic             MemErr,
  output logic [CNT_W-1:0] Retired
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic             Trap,
  input  logic             TrapAck
`endif
);

  // Timeout counter only needs to reach MEM_TIMEOUT-1.
  localparam int            TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit            TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       retire;
  logic [5:0] enc_func;
  logic       enc_legal;
  logic       is_store;
  logic       timeout_hit;

  // Only the control-relevant IR fields are kept; register numbers and
  // immediates live in the datapath's own IR.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

`ifndef OVERFLOW_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = Overflow;
`endif

  func_encoder u_func_encoder (
    .funct7 (funct7_q),
    .funct3 (funct3_q),
    .func   (enc_func),
    .legal  (enc_legal)
  );

  assign is_store    = (opcode_q == OP_STORE);
  assign timeout_hit = TO_EN && (tcnt_q == TO_LAST);
  assign Retired     = retired_q;

  // Next-state, IR capture, timeout counter and retire counter.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    tcnt_d    = tcnt_q;
    retired_d = retired_q;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (InstrValid) begin
          opcode_d = Instr[6:0];
          funct3_d = Instr[14:12];
          funct7_d = Instr[31:25];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
          state_d = S_MEMADDR;
        end else if (opcode_q == OP_RTYPE && enc_legal) begin
          state_d = S_EXEC_R;
        end else if (opcode_q == OP_BRANCH && funct3_q == 3'b000) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_MEMADDR: begin
        tcnt_d  = '0;
        state_d = S_MEM_ACCESS;
      end
      S_MEM_ACCESS: begin
        // An ack arriving in the expiry cycle takes priority over the timeout.
        if (MemAck) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB_MEM;
          end
        end else if (timeout_hit) begin
          state_d = S_FETCH;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WB_MEM: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_R: begin
`ifdef OVERFLOW_TRAP_EN
        if (Overflow && (enc_func == FUNC_ADD || enc_func == FUNC_SUB)) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_WB_ALU;
        end
`else
        state_d = S_WB_ALU;
`endif
      end
      S_WB_ALU: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end
`ifdef OVERFLOW_TRAP_EN
      S_TRAP: begin
        if (TrapAck) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      tcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      tcnt_q    <= tcnt_d;
      retired_q <= retired_d;
    end
  end

  // Control outputs. While rst_n is low everything is held at 0 so the
  // datapath sees no request even though the state is already FETCH.
  always_comb begin
    InstrReq = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSource = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RS2;
    ALUOp    = ALUOP_ADD;
    Func     = FUNC_NONE;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    Illegal  = 1'b0;
    MemErr   = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    Trap     = 1'b0;
`endif
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          InstrReq = 1'b1;
          ALUSrcB  = SRCB_FOUR;
          if (InstrValid) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_DECODE: begin
          // Branch target (OldPC + imm) is computed speculatively here.
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_ACCESS: begin
          MemRead  = !is_store;
          MemWrite = is_store;
          MemErr   = !MemAck && timeout_hit;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNC;
          Func    = enc_func;
        end
        S_WB_ALU: begin
          ALUOp    = ALUOP_FUNC;
          Func     = enc_func;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_SUB;
          PCSource = 1'b1;
          PCWrite  = Zero;
        end
        S_ILLEGAL: begin
          Illegal = 1'b1;
        end
`ifdef OVERFLOW_TRAP_EN
        S_TRAP: begin
          Trap = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
// Directed bench for multicycle_main_control (MEM_TIMEOUT=4). Each
// instruction is described by its class; the bench expands the class into the
// expected per-cycle control vector and compares every cycle.
// Optional feature macro: OVERFLOW_TRAP_EN (Trap/TrapAck ports).
module tb_multicycle_main_control;

  localparam int T = 4;

  typedef struct packed {
    logic       instr_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [5:0] func;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
    logic       mem_err;
    logic       trap;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instr;
  logic        InstrValid, Zero, Overflow, MemAck;
  logic        InstrReq, IRWrite, PCWrite, PCSource, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [5:0]  Func;
  logic        MemRead, MemWrite, RegWrite, MemtoReg, Illegal, MemErr;
  logic [31:0] Retired;
`ifdef OVERFLOW_TRAP_EN
  logic        Trap, TrapAck;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_retired = 0;
  int obs_memread = 0;
  int obs_memerr = 0;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .InstrValid(InstrValid),
    .Zero(Zero), .Overflow(Overflow), .MemAck(MemAck),
    .InstrReq(InstrReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Func(Func), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Illegal(Illegal),
    .MemErr(MemErr), .Retired(Retired)
`ifdef OVERFLOW_TRAP_EN
    , .Trap(Trap), .TrapAck(TrapAck)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic outs_t dut_outs();
    outs_t o;
    o = '0;
    o.instr_req = InstrReq;  o.ir_write = IRWrite;   o.pc_write = PCWrite;
    o.pc_source = PCSource;  o.src_a = ALUSrcA;      o.src_b = ALUSrcB;
    o.alu_op = ALUOp;        o.func = Func;          o.mem_read = MemRead;
    o.mem_write = MemWrite;  o.reg_write = RegWrite; o.mem_to_reg = MemtoReg;
    o.illegal = Illegal;     o.mem_err = MemErr;
`ifdef OVERFLOW_TRAP_EN
    o.trap = Trap;
`endif
    return o;
  endfunction

  // Instruction classes: 0 R-type, 1 load, 2 store, 3 beq, 4 illegal.
  function automatic bit r_func(input logic [31:0] ins, output logic [5:0] f);
    logic [9:0] key;
    key = {ins[31:25], ins[14:12]};
    f = 6'b000000;
    case (key)
      10'b0000000_000: f = 6'b100000;
      10'b0100000_000: f = 6'b100010;
      10'b0000000_111: f = 6'b100100;
      10'b0000000_110: f = 6'b100101;
      10'b0000000_010: f = 6'b101010;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic int kind_of(input logic [31:0] ins);
    logic [5:0] f;
    case (ins[6:0])
      7'b0000011: return 1;
      7'b0100011: return 2;
      7'b1100011: return (ins[14:12] == 3'b000) ? 3 : 4;
      7'b0110011: return r_func(ins, f) ? 0 : 4;
      default:    return 4;
    endcase
  endfunction

  task automatic clr();
    InstrValid = 1'b0; MemAck = 1'b0; Zero = 1'b0; Overflow = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    TrapAck = 1'b0;
`endif
  endtask

  // Drive inputs the current state must ignore.
  task automatic junk(input bit noise);
    if (noise) begin
      InstrValid = 1'b1; MemAck = 1'b1; Overflow = 1'b1; Zero = 1'b1;
      Instr = $urandom;
    end
  endtask

  // One cycle: compare at the falling edge, then advance past the rising edge.
  task automatic step(input outs_t e, input string nm, input bit rt);
    outs_t act;
    @(negedge clk);
    act = dut_outs();
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, act, e);
    end
    tests++;
    if (Retired !== 32'(m_retired)) begin
      fails++;
      $display("FAIL %s_retired cyc=%0d got=%0d required=%0d", nm, cyc, Retired, m_retired);
    end
    if (act.mem_read) obs_memread++;
    if (act.mem_err) obs_memerr++;
    if (rt) m_retired++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic lit(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic outs_t ex_fetch(input bit valid);
    outs_t e;
    e = '0; e.instr_req = 1'b1; e.src_b = 2'b01;
    e.ir_write = valid; e.pc_write = valid;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_retired = 0;
    cyc++;
  endtask

  task automatic do_instr(input logic [31:0] ins, input int fetch_wait,
                          input int ack_at, input bit zero, input bit ovf,
                          input bit noise);
    outs_t e;
    logic [5:0] f;
    int k;
    bit acked, trap, ok;
    for (int i = 0; i < fetch_wait; i++) begin
      clr(); Instr = $urandom;
      step(ex_fetch(1'b0), "fetch_wait", 1'b0);
    end
    clr(); Instr = ins; InstrValid = 1'b1;
    step(ex_fetch(1'b1), "fetch", 1'b0);
    clr(); junk(noise);
    e = '0; e.src_b = 2'b10;
    step(e, "decode", 1'b0);
    k = kind_of(ins);
    case (k)
      0: begin
        ok = r_func(ins, f);
        clr(); junk(noise); Overflow = ovf;
        e = '0; e.src_a = 1'b1; e.alu_op = 2'b10; e.func = f;
        step(e, "exec_r", 1'b0);
        trap = 1'b0;
`ifdef OVERFLOW_TRAP_EN
        trap = ovf && (f == 6'b100000 || f == 6'b100010);
`endif
        if (trap) begin
          for (int i = 0; i < 3; i++) begin
            clr();
`ifdef OVERFLOW_TRAP_EN
            TrapAck = (i == 2);
`endif
            e = '0; e.trap = 1'b1;
            step(e, "trap", 1'b0);
          end
        end else begin
          clr(); junk(noise);
          e = '0; e.alu_op = 2'b10; e.func = f; e.reg_write = 1'b1;
          step(e, "wb_alu", 1'b1);
        end
      end
      1, 2: begin
        clr(); junk(noise);
        e = '0; e.src_a = 1'b1; e.src_b = 2'b10;
        step(e, "memaddr", 1'b0);
        acked = 1'b0;
        for (int i = 0; i < T; i++) begin
          clr(); MemAck = (i == ack_at);
          e = '0; e.mem_read = (k == 1); e.mem_write = (k == 2);
          if (MemAck) begin
            step(e, "mem_ack", k == 2);
            acked = 1'b1;
            break;
          end
          if (i == T - 1) begin
            e.mem_err = 1'b1;
            step(e, "mem_timeout", 1'b0);
          end else begin
            step(e, "mem_wait", 1'b0);
          end
        end
        if (acked && k == 1) begin
          clr(); junk(noise);
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          step(e, "wb_mem", 1'b1);
        end
      end
      3: begin
        clr(); junk(noise); Zero = zero;
        e = '0; e.src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 1'b1; e.pc_write = zero;
        step(e, "branch", 1'b1);
      end
      default: begin
        for (int i = 0; i < 10; i++) begin
          clr(); junk(noise);
          e = '0; e.illegal = 1'b1;
          step(e, "illegal", 1'b0);
        end
      end
    endcase
  endtask

  initial begin
    logic [5:0] f;
    outs_t e;
    bit ok;
    rst_n = 1'b0; Instr = '0; clr();
    @(posedge clk); #1;
    step('0, "reset", 1'b0);
    rst_n = 1'b1;

    // Pin the bench model with hand-computed values.
    ok = r_func(32'h002081B3, f); lit("model_add_func", int'(f), 32);
    ok = r_func(32'h402081B3, f); lit("model_sub_func", int'(f), 34);
    ok = r_func(32'h0020A1B3, f); lit("model_slt_func", int'(f), 42);
    lit("model_beq_f3_001", kind_of(32'h00209063), 4);

    do_instr(32'h002081B3, 0, -1, 0, 0, 0);            // add
    lit("retired_after_add", int'(Retired), 1);
    do_instr(32'h402081B3, 2, -1, 0, 0, 1);            // sub, noisy
    do_instr(32'h0020A1B3, 0, -1, 0, 0, 0);            // slt
    do_instr(32'h0020F1B3, 1, -1, 0, 0, 1);            // and
    do_instr(32'h0020E1B3, 0, -1, 0, 0, 0);            // or
    obs_memread = 0;
    do_instr(32'h0080A283, 0, 3, 0, 0, 1);             // lw, ack in expiry cycle
    lit("lw_memread_cycles", obs_memread, 4);
    do_instr(32'h0080A283, 0, 0, 0, 0, 0);             // lw, immediate ack
    do_instr(32'h00208063, 0, -1, 1, 0, 0);            // beq taken
    do_instr(32'h00208063, 0, -1, 0, 0, 1);            // beq not taken
    do_instr(32'h0020A023, 0, 1, 0, 0, 1);             // sw acked
    obs_memerr = 0;
    do_instr(32'h0020A023, 0, -1, 0, 0, 0);            // sw timeout
    lit("memerr_pulses", obs_memerr, 1);
    lit("retired_after_timeout", int'(Retired), 10);
    do_instr(32'h002081B3, 0, -1, 0, 1, 0);            // add with overflow
`ifdef OVERFLOW_TRAP_EN
    lit("retired_after_ovf_add", int'(Retired), 10);
`else
    lit("retired_after_ovf_add", int'(Retired), 11);
`endif

    // Reset in the middle of a load abandons the access.
    clr(); Instr = 32'h0080A283; InstrValid = 1'b1;
    step(ex_fetch(1'b1), "fetch", 1'b0);
    clr(); e = '0; e.src_b = 2'b10; step(e, "decode", 1'b0);
    clr(); e = '0; e.src_a = 1'b1; e.src_b = 2'b10; step(e, "memaddr", 1'b0);
    clr(); e = '0; e.mem_read = 1'b1; step(e, "mem_wait", 1'b0);
    do_reset();
    clr(); step(ex_fetch(1'b0), "post_reset_fetch", 1'b0);
    lit("retired_after_reset", int'(Retired), 0);

    // Illegal encodings stick until reset.
    do_instr(32'h0000007F, 0, -1, 0, 0, 1);
    do_reset();
    lit("illegal_cleared", int'(Illegal), 0);
    do_instr(32'h002091B3, 0, -1, 0, 0, 0);            // unsupported funct
    do_reset();
    do_instr(32'h00209063, 0, -1, 1, 0, 0);            // branch funct3=001
    do_reset();
    do_instr(32'h002081B3, 0, -1, 0, 0, 0);
    lit("retired_after_recover", int'(Retired), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
